// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame geometry and default baud divisor.
// Used by the receiver and the future transmitter.
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int CLKS_PER_BIT_DEFAULT = 868;  // 100 MHz / 115200

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } uart_state_t;

  // Counter width that can hold 0..clks-1, never narrower than one bit.
  function automatic int cnt_width(input int clks);
    return (clks > 2) ? $clog2(clks) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Both flops reset to INIT so an idle-high line reads idle out of reset.
module sync_2ff #(
  parameter logic INIT = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= INIT;
      q    <= INIT;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with a one-entry valid/ready holding register.
// Framing errors and dropped bytes are reported as single-cycle pulses.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int              CW       = cnt_width(CLKS_PER_BIT);
  localparam int              IW       = $clog2(DATA_BITS);
  localparam logic [CW-1:0]   CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   CNT_HALF = CW'(HALF_BIT - 1);
  localparam logic [IW-1:0]   IDX_LAST = IW'(DATA_BITS - 1);

  logic                 rx_s;
  uart_state_t          state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 stop_ok;

  sync_2ff #(.INIT(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (serial_rx),
    .q   (rx_s)
  );

  // Stop bit sampled high: the shift register now holds a complete byte.
  assign stop_ok = (state == ST_STOP) && (cnt == CNT_LAST) && rx_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state <= ST_START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end

        // Re-check the line at mid start bit; a high here was a glitch.
        ST_START: begin
          if (cnt == CNT_HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            if (rx_s) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              state <= ST_DATA;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        ST_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt            <= '0;
            shift[bit_idx] <= rx_s;
            if (bit_idx == IDX_LAST) state <= ST_STOP;
            else                     bit_idx <= bit_idx + IW'(1);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        // Leaving mid stop bit lets a start edge right after it be caught.
        ST_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              state     <= ST_WAIT_IDLE;
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        // Line held low (break): wait for it to return high before rearming.
        ST_WAIT_IDLE: begin
          if (rx_s) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase

      // A completion in the same cycle as an accept refills the register.
      if (stop_ok) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 16 clocks per bit.
// Inputs change on falling edges; outputs are observed away from the rising edge.
module tb_uart_rx_byte;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       serial_rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int errors = 0;
  int checks = 0;

  // Monitor tallies (written only by the monitor process).
  int         vhi = 0, vlo = 0, ferr = 0, ovr = 0;
  logic [7:0] acc_q[$];

  int b_vhi, b_vlo, b_ferr, b_ovr, b_acc;

  always #5 clk = ~clk;

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .serial_rx (serial_rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always @(negedge clk) begin
    #1;
    if (rx_valid) vhi++; else vlo++;
    if (frame_err) ferr++;
    if (overrun) ovr++;
    if (rx_valid && rx_ready && !rst) acc_q.push_back(rx_data);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_vhi  = vhi;
    b_vlo  = vlo;
    b_ferr = ferr;
    b_ovr  = ovr;
    b_acc  = acc_q.size();
  endtask

  // Start bit plus eight data bits, LSB first; leaves the caller at the stop-bit boundary.
  task automatic send_head(input logic [7:0] b);
    serial_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serial_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_head(b);
    serial_rx = stop;
    repeat (CPB) @(negedge clk);
    serial_rx = 1'b1;
  endtask

  initial begin
    logic [7:0] last;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_data", 32'(rx_data), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 0xA5 with consumer always ready: one-cycle valid pulse
    rx_ready = 1'b1;
    snap();
    send_byte(8'hA5, 1'b1);
    repeat (10) @(negedge clk);
    chk("a5_vcycles", 32'(vhi - b_vhi), 32'd1);
    chk("a5_count", 32'(acc_q.size() - b_acc), 32'd1);
    last = acc_q[$];
    chk("a5_data", 32'(last), 32'hA5);
    chk("a5_ferr", 32'(ferr - b_ferr), 32'd0);
    chk("a5_ovr", 32'(ovr - b_ovr), 32'd0);

    // 0x3C then 0xF0 back to back with no consumer: second byte overruns
    rx_ready = 1'b0;
    snap();
    send_byte(8'h3C, 1'b1);
    send_byte(8'hF0, 1'b1);
    repeat (10) @(negedge clk);
    chk("ovr_valid", 32'(rx_valid), 32'd1);
    chk("ovr_data", 32'(rx_data), 32'h3C);
    chk("ovr_pulses", 32'(ovr - b_ovr), 32'd1);
    chk("ovr_noacc", 32'(acc_q.size() - b_acc), 32'd0);
    rx_ready = 1'b1;
    @(negedge clk);
    chk("ovr_drop", 32'(rx_valid), 32'd0);
    repeat (2) @(negedge clk);
    last = acc_q[$];
    chk("ovr_accdata", 32'(last), 32'h3C);

    // 0x55 with low stop bit, line held low 40 more cycles
    snap();
    send_head(8'h55);
    serial_rx = 1'b0;
    repeat (CPB + 20) @(negedge clk);
    chk("fe_busy_low", 32'(busy), 32'd1);
    repeat (20) @(negedge clk);
    serial_rx = 1'b1;
    repeat (6) @(negedge clk);
    chk("fe_busy_idle", 32'(busy), 32'd0);
    chk("fe_pulses", 32'(ferr - b_ferr), 32'd1);
    chk("fe_novalid", 32'(vhi - b_vhi), 32'd0);
    repeat (10) @(negedge clk);
    send_byte(8'h81, 1'b1);
    repeat (10) @(negedge clk);
    last = acc_q[$];
    chk("fe_next_data", 32'(last), 32'h81);
    chk("fe_next_cnt", 32'(acc_q.size() - b_acc), 32'd1);

    // 4-cycle glitch on idle line
    snap();
    serial_rx = 1'b0;
    repeat (4) @(negedge clk);
    serial_rx = 1'b1;
    repeat (2) @(negedge clk);
    chk("gl_busy_start", 32'(busy), 32'd1);
    repeat (12) @(negedge clk);
    chk("gl_busy_idle", 32'(busy), 32'd0);
    chk("gl_novalid", 32'(vhi - b_vhi), 32'd0);
    chk("gl_noferr", 32'(ferr - b_ferr), 32'd0);

    // Reset in the middle of the data bits of 0xFF
    serial_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    serial_rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    chk("mr_busy_data", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mr_valid", 32'(rx_valid), 32'd0);
    chk("mr_data", 32'(rx_data), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_ferr", 32'(frame_err), 32'd0);
    chk("mr_ovr", 32'(overrun), 32'd0);
    rst = 1'b0;
    snap();
    repeat (200) @(negedge clk);
    chk("mr_quiet_v", 32'(vhi - b_vhi), 32'd0);
    chk("mr_quiet_fe", 32'(ferr - b_ferr), 32'd0);
    send_byte(8'h12, 1'b1);
    repeat (10) @(negedge clk);
    last = acc_q[$];
    chk("mr_next_data", 32'(last), 32'h12);

    // Accept of 0x01 lands exactly on the completion cycle of 0x02
    rx_ready = 1'b0;
    send_byte(8'h01, 1'b1);
    repeat (10) @(negedge clk);
    chk("co_hold_valid", 32'(rx_valid), 32'd1);
    chk("co_hold_data", 32'(rx_data), 32'h01);
    snap();
    send_head(8'h02);
    serial_rx = 1'b1;
    repeat (10) @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    repeat (10) @(negedge clk);
    chk("co_valid", 32'(rx_valid), 32'd1);
    chk("co_data", 32'(rx_data), 32'h02);
    chk("co_ovr", 32'(ovr - b_ovr), 32'd0);
    chk("co_nogap", 32'(vlo - b_vlo), 32'd0);
    chk("co_acc_cnt", 32'(acc_q.size() - b_acc), 32'd1);
    last = acc_q[$];
    chk("co_acc_data", 32'(last), 32'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
